// File: rtl/pe_dot_sequencer_pkg.sv
// +----------------------------------------------------------------------------+
// | pe_pkg : state encoding and default widths shared by the PE and sequencer. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package pe_pkg;

  localparam int c_PRECISION        = 8;
  localparam int c_OUTPUT_PRECISION = 32;
  localparam int c_ADDR_WIDTH       = 8;
  localparam int c_TIMEOUT          = 255;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/pe_dot_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | pe_dot_sequencer_if : job, operand-memory, PE and result signals.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pe_dot_sequencer_if
  import pe_pkg::*;
#(
  parameter int PRECISION        = c_PRECISION,
  parameter int OUTPUT_PRECISION = c_OUTPUT_PRECISION,
  parameter int ADDR_WIDTH       = c_ADDR_WIDTH
);

  logic                        start;
  logic [ADDR_WIDTH-1:0]       len;
  logic [ADDR_WIDTH-1:0]       a_base;
  logic [ADDR_WIDTH-1:0]       b_base;

  logic                        mem_rd_en;
  logic [ADDR_WIDTH-1:0]       a_addr;
  logic [ADDR_WIDTH-1:0]       b_addr;
  logic [PRECISION-1:0]        a_rdata;
  logic [PRECISION-1:0]        b_rdata;

  logic [PRECISION-1:0]        pe_a;
  logic [PRECISION-1:0]        pe_b;
  logic                        pe_start;
  logic                        pe_ack;
  logic                        pe_ready;
  logic [OUTPUT_PRECISION-1:0] pe_result;

  logic                        busy;
  logic                        result_valid;
  logic [OUTPUT_PRECISION-1:0] result;
  logic                        overflow;
  logic                        error;
  logic                        result_ready;

  modport master (
    input  start, len, a_base, b_base, a_rdata, b_rdata,
           pe_ready, pe_result, result_ready,
    output mem_rd_en, a_addr, b_addr, pe_a, pe_b, pe_start, pe_ack,
           busy, result_valid, result, overflow, error
  );

  modport slave (
    output start, len, a_base, b_base, a_rdata, b_rdata,
           pe_ready, pe_result, result_ready,
    input  mem_rd_en, a_addr, b_addr, pe_a, pe_b, pe_start, pe_ack,
           busy, result_valid, result, overflow, error
  );

endinterface

`default_nettype wire

// File: rtl/pe_dot_sequencer.sv
// +----------------------------------------------------------------------------+
// | pe_dot_sequencer : walks one PE through an N-element dot product.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pe_dot_sequencer
  import pe_pkg::*;
#(
  parameter int PRECISION        = c_PRECISION,
  parameter int OUTPUT_PRECISION = c_OUTPUT_PRECISION,
  parameter int ADDR_WIDTH       = c_ADDR_WIDTH,
  parameter int TIMEOUT          = c_TIMEOUT
) (
  input  logic                 CLK,
  input  logic                 reset,
  pe_dot_sequencer_if.master   seq_if
);

  localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_t                  r_state;
  logic [ADDR_WIDTH-1:0]       r_len;
  logic [ADDR_WIDTH-1:0]       r_idx;
  logic [c_TW-1:0]             r_tcnt;
  logic [OUTPUT_PRECISION-1:0] r_acc;
  logic                        r_overflow;
  logic                        r_error;
  logic                        r_busy;
  logic                        r_result_valid;
  logic                        r_mem_rd_en;
  logic                        r_pe_start;
  logic                        r_pe_ack;
  logic [ADDR_WIDTH-1:0]       r_a_addr;
  logic [ADDR_WIDTH-1:0]       r_b_addr;
  logic [PRECISION-1:0]        r_pe_a;
  logic [PRECISION-1:0]        r_pe_b;

  logic [OUTPUT_PRECISION:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, seq_if.pe_result};

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state        <= IDLE;
      r_len          <= '0;
      r_idx          <= '0;
      r_tcnt         <= '0;
      r_acc          <= '0;
      r_overflow     <= 1'b0;
      r_error        <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_mem_rd_en    <= 1'b0;
      r_pe_start     <= 1'b0;
      r_pe_ack       <= 1'b0;
      r_a_addr       <= '0;
      r_b_addr       <= '0;
      r_pe_a         <= '0;
      r_pe_b         <= '0;
    end else begin
      // Strobes are one-cycle pulses unless a transition below re-asserts them.
      r_mem_rd_en <= 1'b0;
      r_pe_start  <= 1'b0;
      r_pe_ack    <= 1'b0;

      case (r_state)
        IDLE: begin
          if (seq_if.start) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_error    <= 1'b0;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            if (seq_if.len != '0) begin
              r_len       <= seq_if.len;
              r_a_addr    <= seq_if.a_base;
              r_b_addr    <= seq_if.b_base;
              r_mem_rd_en <= 1'b1;
              r_state     <= FETCH;
            end else begin
              r_result_valid <= 1'b1;
              r_state        <= DONE;
            end
          end
        end

        FETCH: begin
          r_pe_ack <= 1'b1;
          r_state  <= LOAD;
        end

        LOAD: begin
          r_pe_a     <= seq_if.a_rdata;
          r_pe_b     <= seq_if.b_rdata;
          r_pe_start <= 1'b1;
          r_state    <= ISSUE;
        end

        ISSUE: begin
          r_tcnt  <= '0;
          r_state <= WAIT;
        end

        WAIT: begin
          if (seq_if.pe_ready) begin
            r_acc      <= w_sum[OUTPUT_PRECISION-1:0];
            r_overflow <= r_overflow | w_sum[OUTPUT_PRECISION];
            if (r_idx == r_len - 1'b1) begin
              r_result_valid <= 1'b1;
              r_state        <= DONE;
            end else begin
              r_idx       <= r_idx + 1'b1;
              r_a_addr    <= r_a_addr + 1'b1;
              r_b_addr    <= r_b_addr + 1'b1;
              r_mem_rd_en <= 1'b1;
              r_state     <= FETCH;
            end
          end else if (r_tcnt == c_TW'(TIMEOUT - 1)) begin
            // Abort leaves the partial sum in place so the consumer can inspect it.
            r_error        <= 1'b1;
            r_result_valid <= 1'b1;
            r_state        <= DONE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end

        DONE: begin
          if (seq_if.result_ready) begin
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign seq_if.mem_rd_en    = r_mem_rd_en;
  assign seq_if.a_addr       = r_a_addr;
  assign seq_if.b_addr       = r_b_addr;
  assign seq_if.pe_a         = r_pe_a;
  assign seq_if.pe_b         = r_pe_b;
  assign seq_if.pe_start     = r_pe_start;
  assign seq_if.pe_ack       = r_pe_ack;
  assign seq_if.busy         = r_busy;
  assign seq_if.result_valid = r_result_valid;
  assign seq_if.result       = r_acc;
  assign seq_if.overflow     = r_overflow;
  assign seq_if.error        = r_error;

endmodule

`default_nettype wire
